// File: rtl/rtc_pkg.sv
// Shared time-of-day types and constants for the RTC and the alarm trigger stage.
package rtc_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [HOUR_W-1:0] MAX_HOUR = HOUR_W'(23);
    localparam logic [MIN_W-1:0]  MAX_MIN  = MIN_W'(59);
    localparam logic [SEC_W-1:0]  MAX_SEC  = SEC_W'(59);

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } rtc_time_t;

    function automatic logic time_valid(input rtc_time_t t);
        return (t.hour <= MAX_HOUR) && (t.min <= MAX_MIN) && (t.sec <= MAX_SEC);
    endfunction

    function automatic logic is_day_end(input rtc_time_t t);
        return (t.hour == MAX_HOUR) && (t.min == MAX_MIN) && (t.sec == MAX_SEC);
    endfunction

    // Fields wrap by comparing against their maximum, not by 6-bit overflow.
    function automatic rtc_time_t time_advance(input rtc_time_t t);
        rtc_time_t n;
        n = t;
        if (t.sec == MAX_SEC) begin
            n.sec = '0;
            if (t.min == MAX_MIN) begin
                n.min  = '0;
                n.hour = (t.hour == MAX_HOUR) ? '0 : t.hour + HOUR_W'(1);
            end else begin
                n.min = t.min + MIN_W'(1);
            end
        end else begin
            n.sec = t.sec + SEC_W'(1);
        end
        return n;
    endfunction

endpackage

// File: rtl/rtc_timekeeper_if.sv
// Control and time bus between the user-interface logic (master) and the RTC (slave).
interface rtc_timekeeper_if;
    import rtc_pkg::*;

    logic              run;
    logic              time_set;
    logic [HOUR_W-1:0] set_hour;
    logic [MIN_W-1:0]  set_min;
    logic [SEC_W-1:0]  set_sec;
    logic [HOUR_W-1:0] hour_rtc;
    logic [MIN_W-1:0]  min_rtc;
    logic [SEC_W-1:0]  sec_rtc;
    logic              sec_tick;
    logic              day_tick;
    logic              set_err;

    modport master (
        output run, time_set, set_hour, set_min, set_sec,
        input  hour_rtc, min_rtc, sec_rtc, sec_tick, day_tick, set_err
    );

    modport slave (
        input  run, time_set, set_hour, set_min, set_sec,
        output hour_rtc, min_rtc, sec_rtc, sec_tick, day_tick, set_err
    );

endinterface

// File: rtl/rtc_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV clocks while run is high.
// RTC_FAST_SIM_EN selects DIV = FAST_DIV instead of CLK_HZ/TICK_HZ.
module rtc_tick_gen #(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned TICK_HZ  = 1,
    parameter int unsigned FAST_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

`ifdef RTC_FAST_SIM_EN
    localparam bit FAST_SIM = 1'b1;
`else
    localparam bit FAST_SIM = 1'b0;
`endif

    localparam int unsigned DIV   = FAST_SIM ? FAST_DIV : CLK_HZ / TICK_HZ;
    localparam int          CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (run) begin
            count_q <= (count_q == LAST) ? '0 : count_q + CNT_W'(1);
        end
    end

    assign tick = run && (count_q == LAST);

endmodule

// File: rtl/rtc_timekeeper.sv
// 24-hour HH:MM:SS real-time clock with time-set load, per-second and per-day strobes.
// Tick rate is chosen in rtc_tick_gen; RTC_FAST_SIM_EN shortens it for simulation.
module rtc_timekeeper #(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned TICK_HZ  = 1,
    parameter int unsigned FAST_DIV = 10
) (
    input  logic             clk,
    input  logic             rst,
    rtc_timekeeper_if.slave  bus
);
    import rtc_pkg::*;

    logic      tick;
    logic      load;
    logic      set_bad;
    rtc_time_t set_val;
    rtc_time_t time_q;
    rtc_time_t time_next;
    logic      sec_tick_q;
    logic      day_tick_q;
    logic      set_err_q;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        set_val   = '{hour: bus.set_hour, min: bus.set_min, sec: bus.set_sec};
        load      = bus.time_set && time_valid(set_val);
        set_bad   = bus.time_set && !time_valid(set_val);
        time_next = time_advance(time_q);
    end

    rtc_tick_gen #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .FAST_DIV (FAST_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .run   (bus.run),
        .clear (load),
        .tick  (tick)
    );

    // A valid load beats a coincident tick; a rejected load lets counting continue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            time_q     <= '0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            set_err_q  <= 1'b0;
        end else begin
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            set_err_q  <= set_bad;
            if (load) begin
                time_q <= set_val;
            end else if (tick) begin
                time_q     <= time_next;
                sec_tick_q <= 1'b1;
                day_tick_q <= is_day_end(time_q);
            end
        end
    end

    assign bus.hour_rtc = time_q.hour;
    assign bus.min_rtc  = time_q.min;
    assign bus.sec_rtc  = time_q.sec;
    assign bus.sec_tick = sec_tick_q;
    assign bus.day_tick = day_tick_q;
    assign bus.set_err  = set_err_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Randomized and directed bench for rtc_timekeeper against a seconds-of-day reference model (DIV = 10).
module tb_rtc_timekeeper;

    localparam int DIV = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rtc_timekeeper_if bus ();

    rtc_timekeeper #(
        .CLK_HZ   (10),
        .TICK_HZ  (1),
        .FAST_DIV (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: time as seconds since midnight plus a prescaler phase.
    int m_sod;
    int m_phase;
    bit m_st;
    bit m_dt;
    bit m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sod   = 0;
        m_phase = 0;
        m_st    = 0;
        m_dt    = 0;
        m_err   = 0;
    endtask

    task automatic model_edge(input bit run, input bit ts, input int h, input int m, input int s);
        m_st  = 0;
        m_dt  = 0;
        m_err = 0;
        if (ts && h <= 23 && m <= 59 && s <= 59) begin
            m_sod   = h * 3600 + m * 60 + s;
            m_phase = 0;
        end else begin
            if (ts) m_err = 1;
            if (run) begin
                if (m_phase == DIV - 1) begin
                    m_phase = 0;
                    m_sod   = (m_sod + 1) % 86400;
                    m_st    = 1;
                    m_dt    = (m_sod == 0);
                end else begin
                    m_phase++;
                end
            end
        end
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ".hour"},     32'(bus.hour_rtc), m_sod / 3600);
        check({ctx, ".min"},      32'(bus.min_rtc),  (m_sod / 60) % 60);
        check({ctx, ".sec"},      32'(bus.sec_rtc),  m_sod % 60);
        check({ctx, ".sec_tick"}, 32'(bus.sec_tick), 32'(m_st));
        check({ctx, ".day_tick"}, 32'(bus.day_tick), 32'(m_dt));
        check({ctx, ".set_err"},  32'(bus.set_err),  32'(m_err));
    endtask

    // Drive inputs, take one clock edge, update the model and compare 1 ns later.
    task automatic cycle(input bit run, input bit ts, input int h, input int m, input int s);
        bus.run      = run;
        bus.time_set = ts;
        bus.set_hour = 5'(h);
        bus.set_min  = 6'(m);
        bus.set_sec  = 6'(s);
        @(posedge clk);
        model_edge(run, ts, h, m, s);
        #1;
        compare_all("cyc");
    endtask

    task automatic wait_tick(output int lat);
        lat = -1;
        for (int i = 1; i <= 3 * DIV; i++) begin
            cycle(1, 0, 0, 0, 0);
            if (bus.sec_tick === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    int lat;
    int day_seen;
    int h_r, m_r, s_r;

    initial begin
        bus.run      = 1'b0;
        bus.time_set = 1'b0;
        bus.set_hour = '0;
        bus.set_min  = '0;
        bus.set_sec  = '0;
        model_reset();

        // Outputs held at 00:00:00 during reset, first tick DIV cycles after release.
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        rst = 1'b1;
        wait_tick(lat);
        check("first_tick_latency", lat, DIV);
        check("sec_after_first_tick", 32'(bus.sec_rtc), 1);

        // Day rollover from 23:59:58.
        cycle(1, 1, 23, 59, 58);
        day_seen = 0;
        for (int i = 0; i < 2 * DIV + 2; i++) begin
            cycle(1, 0, 0, 0, 0);
            if (bus.day_tick === 1'b1) begin
                day_seen++;
                check("day_tick_time", 32'({bus.hour_rtc, bus.min_rtc, bus.sec_rtc}), 0);
                check("day_tick_sec_tick", 32'(bus.sec_tick), 1);
            end
        end
        check("day_tick_count", day_seen, 1);

        // Minute and hour carries.
        cycle(1, 1, 1, 2, 59);
        repeat (DIV) cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 1, 59, 59);
        repeat (DIV) cycle(1, 0, 0, 0, 0);

        // Out-of-range loads are rejected with set_err.
        repeat (3) cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 24, 0, 0);
        cycle(1, 1, 10, 60, 0);
        repeat (2 * DIV) cycle(1, 0, 0, 0, 0);

        // Load on the exact tick cycle: set wins, next advance DIV cycles later.
        for (int i = 0; i < 2 * DIV && m_phase != DIV - 1; i++) cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 5, 6, 7);
        wait_tick(lat);
        check("tick_after_set_on_tick", lat, DIV);
        check("sec_after_set_on_tick", 32'(bus.sec_rtc), 8);

        // Held time_set keeps reloading; run=0 does not block loads.
        repeat (4) cycle(1, 1, 12, 34, 56);
        cycle(0, 1, 12, 34, 50);
        wait_tick(lat);
        check("tick_after_held_set", lat, DIV);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    h_r = $urandom_range(0, 31);
                    m_r = $urandom_range(0, 63);
                    s_r = $urandom_range(0, 63);
                end
                1: begin
                    h_r = 23;
                    m_r = 59;
                    s_r = $urandom_range(50, 59);
                end
                default: begin
                    h_r = $urandom_range(0, 23);
                    m_r = $urandom_range(0, 59);
                    s_r = $urandom_range(0, 59);
                end
            endcase
            cycle(bit'($urandom_range(0, 7) != 0), bit'($urandom_range(0, 24) == 0), h_r, m_r, s_r);
        end

        // Freeze with run=0, then asynchronous reset between edges.
        cycle(1, 1, 7, 8, 9);
        repeat (13) cycle(1, 0, 0, 0, 0);
        repeat (25) cycle(0, 0, 0, 0, 0);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all("async_reset");
        rst = 1'b1;

        // Reset right after a strobe edge clears the strobe immediately.
        cycle(1, 1, 3, 4, 5);
        wait_tick(lat);
        check("pre_reset_tick", lat, DIV);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all("strobe_reset");
        #3;
        rst = 1'b1;
        wait_tick(lat);
        check("tick_after_second_reset", lat, DIV);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
